memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/memory_access_unit.sv | 139 +++++++++++++
 tb/tb_memory_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Load/store unit for the memory stage: checks size/alignment, drives one
// memory request per accepted access, stalls upstream stages and formats loads.
module memory_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  FaultM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_access;
  logic        w_fault;
  logic        w_accept;

  logic [31:0] r_addr;
  logic [1:0]  r_off;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        shifted;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  // Decode: unsigned sizes are load-only, and H/W must be naturally aligned.
  always_comb begin
    w_fault = 1'b0;
    case (funct3M)
      3'b000:  w_fault = 1'b0;
      3'b001:  w_fault = ALUResultM[0];
      3'b010:  w_fault = (ALUResultM[1:0] != 2'b00);
      3'b100:  w_fault = MemWriteM;
      3'b101:  w_fault = MemWriteM | ALUResultM[0];
      default: w_fault = 1'b1;
    endcase
  end

  assign w_access = MemReadM | MemWriteM;
  assign w_accept = !rst && (r_state == IDLE) && w_access && !w_fault;
  assign FaultM   = !rst && (r_state == IDLE) && w_access && w_fault;
  assign StallM   = !rst && (w_accept || (r_state == BUSY));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (mem_ready) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Request fields are captured once at accept so the bus stays stable while
  // the pipeline inputs wander during wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_off    <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= {ALUResultM[31:2], 2'b00};
        r_off    <= ALUResultM[1:0];
        r_we     <= MemWriteM;
        r_be     <= store_be(funct3M[1:0], ALUResultM[1:0]);
        r_wdata  <= store_lanes(funct3M[1:0], WriteDataM);
        r_funct3 <= funct3M;
      end
      if ((r_state == BUSY) && mem_ready && !r_we)
        r_rdata <= load_format(r_funct3, r_off, mem_rdata);
    end
  end

  assign mem_req   = (r_state == BUSY);
  assign mem_we    = mem_req & r_we;
  assign mem_be    = mem_req ? r_be : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ReadDataM = r_rdata;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, faults, reset and
// back-to-back accesses with hand-computed expectations.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, FaultM;
  logic [31:0] ReadDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .FaultM(FaultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  // Drives one access and observes it until the DONE cycle (or a fault).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdata,
                            output int stall_cnt, output int req_cnt, output logic fault,
                            output logic [31:0] a, output logic [3:0] be,
                            output logic [31:0] wdo, output logic we,
                            output logic stable, output logic [31:0] rdout,
                            output logic tmo);
    stall_cnt = 0; req_cnt = 0; fault = 1'b0; a = '0; be = '0; wdo = '0;
    we = 1'b0; stable = 1'b1; rdout = '0; tmo = 1'b1;
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr;
    WriteDataM = wd; mem_rdata = rdata; mem_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #4;
      if (c == 0) fault = FaultM;
      if (StallM) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          a = mem_addr; be = mem_be; wdo = mem_wdata; we = mem_we;
        end else if (mem_addr !== a || mem_be !== be || mem_wdata !== wdo || mem_we !== we) begin
          stable = 1'b0;
        end
        // Inputs wander while stalled; the latched request must not follow.
        ALUResultM = ALUResultM ^ 32'h0000_0F0C;
        WriteDataM = ~WriteDataM;
        mem_ready  = (req_cnt > waits);
      end else begin
        mem_ready = 1'b0;
      end
      if (!StallM && !mem_req) begin
        rdout = ReadDataM;
        tmo   = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  int          s_cnt, r_cnt;
  logic        flt, we_o, stab, to;
  logic [31:0] a_o, wd_o, rd_o;
  logic [3:0]  be_o;

  task automatic test_reset();
    rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b011;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b1;
    #4;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", StallM); end
    checks++; if (FaultM !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", FaultM); end
    @(posedge clk); #1; @(posedge clk); #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", ReadDataM); end
    rst = 1'b0; MemReadM = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL lw_timeout got %b want 0", to); end
    checks++; if (s_cnt != 2) begin errors++; $display("FAIL lw_stall got %0d want 2", s_cnt); end
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL lw_reqs got %0d want 1", r_cnt); end
    checks++; if (a_o !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", a_o); end
    checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL lw_we got %b want 0", we_o); end
    checks++; if (rd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd_o); end
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lw_no_dup got %b want 0", mem_req); end
  endtask

  task automatic test_load_format();
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (rd_o !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", rd_o); end
    checks++; if (a_o !== 32'h100) begin errors++; $display("FAIL lb_addr got %h want 100", a_o); end
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFFFF,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (rd_o !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", rd_o); end
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80011234,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (rd_o !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h want ffff8001", rd_o); end
    checks++; if (s_cnt != 3) begin errors++; $display("FAIL lh_stall got %0d want 3", s_cnt); end
    run_access(1, 0, 3'b101, 32'h100, 32'h0, 0, 32'h80019234,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (rd_o !== 32'h00009234) begin errors++; $display("FAIL lhu_rdata got %h want 00009234", rd_o); end
  endtask

  task automatic test_store();
    run_access(1, 1, 3'b001, 32'h102, 32'h1234ABCD, 3, 32'h77777777,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (be_o !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", be_o); end
    checks++; if (wd_o !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", wd_o); end
    checks++; if (a_o !== 32'h100) begin errors++; $display("FAIL sh_addr got %h want 100", a_o); end
    checks++; if (we_o !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", we_o); end
    checks++; if (stab !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", stab); end
    checks++; if (r_cnt != 4) begin errors++; $display("FAIL sh_busy got %0d want 4", r_cnt); end
    checks++; if (s_cnt != 5) begin errors++; $display("FAIL sh_stall got %0d want 5", s_cnt); end
    checks++; if (rd_o !== 32'h00009234) begin errors++; $display("FAIL sh_rdata_hold got %h want 00009234", rd_o); end
    run_access(0, 1, 3'b000, 32'h101, 32'h000000EF, 0, 32'h0,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (be_o !== 4'b0010) begin errors++; $display("FAIL sb_be got %b want 0010", be_o); end
    checks++; if (wd_o !== 32'hEFEFEFEF) begin errors++; $display("FAIL sb_wdata got %h want efefefef", wd_o); end
  endtask

  task automatic test_fault();
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 32'h0,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (flt !== 1'b1) begin errors++; $display("FAIL lw_misalign_fault got %b want 1", flt); end
    checks++; if (s_cnt != 0) begin errors++; $display("FAIL lw_misalign_stall got %0d want 0", s_cnt); end
    checks++; if (r_cnt != 0) begin errors++; $display("FAIL lw_misalign_req got %0d want 0", r_cnt); end
    #4;
    checks++; if (FaultM !== 1'b0 || mem_req !== 1'b0) begin errors++;
      $display("FAIL fault_after got fault=%b req=%b want 0 0", FaultM, mem_req); end
    #2;
    run_access(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (flt !== 1'b1 || r_cnt != 0) begin errors++;
      $display("FAIL sbu_fault got fault=%b reqs=%0d want 1 0", flt, r_cnt); end
    run_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (flt !== 1'b1 || r_cnt != 0) begin errors++;
      $display("FAIL f3_011_fault got fault=%b reqs=%0d want 1 0", flt, r_cnt); end
  endtask

  task automatic test_reset_in_busy();
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h100;
    mem_ready = 1'b0; mem_rdata = 32'h55555555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL rst_busy_stall got %b want 0", StallM); end
    @(posedge clk); #1;
    rst = 1'b0; MemReadM = 1'b0; mem_ready = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_busy_req got %b want 0", mem_req); end
    checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rst_busy_rdata got %h want 0", ReadDataM); end
    @(posedge clk); #4;
    checks++; if (ReadDataM !== 32'h0 || mem_req !== 1'b0 || StallM !== 1'b0) begin errors++;
      $display("FAIL rst_busy_after got rdata=%h req=%b stall=%b want 0 0 0", ReadDataM, mem_req, StallM); end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_access(1, 0, 3'b010, 32'h200, 32'h0, 1, 32'h11112222,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (r_cnt != 2 || s_cnt != 3) begin errors++;
      $display("FAIL b2b_lw got reqs=%0d stall=%0d want 2 3", r_cnt, s_cnt); end
    checks++; if (rd_o !== 32'h11112222) begin errors++; $display("FAIL b2b_lw_rdata got %h want 11112222", rd_o); end
    run_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'h0,
               s_cnt, r_cnt, flt, a_o, be_o, wd_o, we_o, stab, rd_o, to);
    checks++; if (s_cnt != 2 || r_cnt != 1) begin errors++;
      $display("FAIL b2b_sw_timing got stall=%0d reqs=%0d want 2 1", s_cnt, r_cnt); end
    checks++; if (a_o !== 32'h204 || be_o !== 4'b1111 || we_o !== 1'b1) begin errors++;
      $display("FAIL b2b_sw_req got addr=%h be=%b we=%b want 204 1111 1", a_o, be_o, we_o); end
    checks++; if (wd_o !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_sw_wdata got %h want cafef00d", wd_o); end
    checks++; if (rd_o !== 32'h11112222) begin errors++; $display("FAIL b2b_rdata_hold got %h want 11112222", rd_o); end
  endtask

  initial begin
    rst = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0; mem_rdata = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_load_format();
    test_store();
    test_fault();
    test_reset_in_busy();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
